// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned LANES = 8;

    // Bit mask covering the low bytes that a given access size returns.
    function automatic logic [63:0] size_mask(input size_e sz);
        logic [63:0] m;
        case (sz)
            SZ_B:    m = 64'h0000_0000_0000_00FF;
            SZ_H:    m = 64'h0000_0000_0000_FFFF;
            SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = '1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one 64-bit RAM word: store strobes and data
// positioning, load extraction and natural-alignment checking.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e       i_size,
    input  logic [2:0]  i_lane,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_raw,
    output logic [7:0]  o_strb,
    output logic [63:0] o_wdata,
    output logic [63:0] o_rdata,
    output logic        o_misaligned
);

    logic [7:0] w_base;

    // Strobe pattern for the size, then shifted to the lane; alignment check.
    always_comb begin
        w_base       = 8'h00;
        o_misaligned = 1'b0;
        case (i_size)
            SZ_B: begin
                w_base       = 8'h01;
                o_misaligned = 1'b0;
            end
            SZ_H: begin
                w_base       = 8'h03;
                o_misaligned = i_lane[0];
            end
            SZ_W: begin
                w_base       = 8'h0F;
                o_misaligned = (i_lane[1:0] != 2'b00);
            end
            default: begin
                w_base       = 8'hFF;
                o_misaligned = (i_lane != 3'b000);
            end
        endcase
        o_strb = w_base << i_lane;
    end

    // Position store data onto its lane and pull load data down to bit 0.
    always_comb begin
        o_wdata = i_wdata << {i_lane, 3'b000};
        o_rdata = (i_raw >> {i_lane, 3'b000}) & size_mask(i_size);
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store at a time, fixed access
// latency, registered response held until the requester takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned              ADDR_WIDTH  = 64,
    parameter int unsigned              DATA_WIDTH  = 64,
    parameter int unsigned              DEPTH_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned              LATENCY     = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic                  i_req_wen,
    input  logic [1:0]            i_req_size,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_e                r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wen;
    size_e                 r_size;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_err;

    logic [63:0] mem [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-4:0] w_index;
    logic [IDX_W-1:0]      w_idx;
    logic [2:0]            w_lane;
    logic                  w_oor;
    logic                  w_misaligned;
    logic                  w_err;
    logic                  w_access;
    logic                  w_commit;
    logic [7:0]            w_strb;
    logic [63:0]           w_wdata_sh;
    logic [63:0]           w_rdata;

    // Decode the captured address into word index, lane and range status.
    always_comb begin
        w_off    = r_addr - BASE_ADDR;
        w_index  = w_off[ADDR_WIDTH-1:3];
        w_idx    = w_off[IDX_W+2:3];
        w_lane   = w_off[2:0];
        w_oor    = (r_addr < BASE_ADDR) || (w_index >= (ADDR_WIDTH-3)'(DEPTH_WORDS));
        w_err    = w_oor || w_misaligned;
        w_access = (r_state == WAIT) && (r_cnt == 4'd0);
        w_commit = w_access && r_wen && !w_err;
    end

    dmem_lane_align u_align (
        .i_size       (r_size),
        .i_lane       (w_lane),
        .i_wdata      (r_wdata),
        .i_raw        (mem[w_idx]),
        .o_strb       (w_strb),
        .o_wdata      (w_wdata_sh),
        .o_rdata      (w_rdata),
        .o_misaligned (w_misaligned)
    );

    // RAM byte writes; only happens on the WAIT->RESP edge of a legal store.
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int unsigned b = 0; b < LANES; b++) begin
                if (w_strb[b]) begin
                    mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Request/response FSM with latency counter and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_size       <= SZ_B;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid && r_req_ready) begin
                        r_addr      <= i_req_addr;
                        r_wen       <= i_req_wen;
                        r_size      <= size_e'(i_req_size);
                        r_wdata     <= i_req_wdata;
                        r_cnt       <= 4'(LATENCY - 1);
                        r_req_ready <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_err;
                        r_resp_rdata <= (w_err || r_wen) ? '0 : w_rdata;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed-vector bench for dmem_responder with hand-computed expectations.
module tb_dmem_responder;

    localparam int unsigned LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int unsigned n_vec;
    int unsigned n_miss;

    dmem_responder #(
        .ADDR_WIDTH  (64),
        .DATA_WIDTH  (64),
        .DEPTH_WORDS (4096),
        .BASE_ADDR   (64'h8000_0000),
        .LATENCY     (LAT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_addr   (req_addr),
        .i_req_wen    (req_wen),
        .i_req_size   (req_size),
        .i_req_wdata  (req_wdata),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Present one request from IDLE, then wait (bounded) for resp_valid and check latency.
    task automatic issue(input logic [63:0] a, input logic w, input logic [1:0] s,
                         input logic [63:0] d);
        int unsigned k;
        req_addr  = a;
        req_wen   = w;
        req_size  = s;
        req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("latency", 64'(k), 64'(LAT));
    endtask

    // Complete the response handshake and check return to IDLE.
    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_hs_valid", {63'd0, resp_valid}, 64'd0);
        chk("post_hs_ready", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic access(input string tag, input logic [63:0] a, input logic w,
                          input logic [1:0] s, input logic [63:0] d,
                          input logic [63:0] exp_rdata, input logic exp_err);
        issue(a, w, s, d);
        chk({tag, "_rdata"}, resp_rdata, exp_rdata);
        chk({tag, "_err"}, {63'd0, resp_err}, {63'd0, exp_err});
        finish_resp();
    endtask

    initial begin
        logic [63:0] held;
        n_vec      = 0;
        n_miss     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_wen    = 1'b0;
        req_size   = 2'd0;
        req_wdata  = '0;
        resp_ready = 1'b0;

        // Reset for three cycles
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", {63'd0, resp_err}, 64'd0);

        // Store dword, then sub-word loads
        access("st_d0", 64'h8000_0000, 1'b1, 2'd3, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
        access("ld_b3", 64'h8000_0003, 1'b0, 2'd0, 64'd0, 64'h55, 1'b0);
        access("ld_h6", 64'h8000_0006, 1'b0, 2'd1, 64'd0, 64'h1122, 1'b0);
        access("ld_w4", 64'h8000_0004, 1'b0, 2'd2, 64'd0, 64'h1122_3344, 1'b0);

        // Byte store merges into the word
        access("st_b1", 64'h8000_0001, 1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, 64'd0, 1'b0);
        access("ld_d0a", 64'h8000_0000, 1'b0, 2'd3, 64'd0, 64'h1122_3344_5566_AB88, 1'b0);

        // Misaligned and out-of-range accesses
        access("ld_w2_mis", 64'h8000_0002, 1'b0, 2'd2, 64'd0, 64'd0, 1'b1);
        access("ld_h1_mis", 64'h8000_0001, 1'b0, 2'd1, 64'd0, 64'd0, 1'b1);
        access("st_low_oor", 64'h7FFF_FFF8, 1'b1, 2'd3, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 1'b1);
        access("ld_high_oor", 64'h8000_8000, 1'b0, 2'd3, 64'd0, 64'd0, 1'b1);
        access("ld_d0b", 64'h8000_0000, 1'b0, 2'd3, 64'd0, 64'h1122_3344_5566_AB88, 1'b0);

        // Last word in range
        access("st_last", 64'h8000_7FF8, 1'b1, 2'd3, 64'h0102_0304_0506_0708, 64'd0, 1'b0);
        access("ld_last_b7", 64'h8000_7FFF, 1'b0, 2'd0, 64'd0, 64'h01, 1'b0);

        // Back-pressure: response held, new request ignored
        issue(64'h8000_0000, 1'b0, 2'd3, 64'd0);
        held = resp_rdata;
        chk("bp_first", held, 64'h1122_3344_5566_AB88);
        req_addr  = 64'h8000_0000;
        req_wen   = 1'b1;
        req_size  = 2'd3;
        req_wdata = 64'd0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_rdata", resp_rdata, 64'h1122_3344_5566_AB88);
            chk("bp_ready", {63'd0, req_ready}, 64'd0);
        end
        req_valid = 1'b0;
        finish_resp();
        access("ld_d0c", 64'h8000_0000, 1'b0, 2'd3, 64'd0, 64'h1122_3344_5566_AB88, 1'b0);

        // Reset during WAIT discards a store
        access("st_d2", 64'h8000_0010, 1'b1, 2'd3, 64'hCAFE_F00D_1234_5678, 64'd0, 1'b0);
        req_addr  = 64'h8000_0010;
        req_wen   = 1'b1;
        req_size  = 2'd0;
        req_wdata = 64'hFF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("wait_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {63'd0, resp_valid}, 64'd0);
        chk("midrst_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("after_rst_valid", {63'd0, resp_valid}, 64'd0);
        @(posedge clk); #1;
        access("ld_d2", 64'h8000_0010, 1'b0, 2'd3, 64'd0, 64'hCAFE_F00D_1234_5678, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
